// File: rtl/uart_tx.sv
// UART transmitter: pops one byte from an external FIFO and shifts it out
// LSB first as start, 8 data bits, optional parity and 1 or 2 stop bits.
module uart_tx #(
  parameter int unsigned ClksPerBit = 868,
  parameter int unsigned ParityEn   = 0,
  parameter int unsigned ParityOdd  = 0,
  parameter int unsigned StopBits   = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tx_en_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_rd_data_i,
  output logic       fifo_rd_en_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);
  // The bit index is reused to count stop bits, so 2 stop bits never
  // need a baud counter wider than one bit period.
  localparam logic [2:0] StopLast = 3'(StopBits - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            parity_q, parity_d;
  logic            done_q, done_d;

  // Parity bit for a byte: XOR of all data bits, inverted for odd parity.
  function automatic logic parity_of(input logic [7:0] d);
    return (^d) ^ (ParityOdd != 0);
  endfunction

  // State, counters and shift register; reset aborts any frame in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: each serial bit reloads the baud counter and ends at 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_en_i && !fifo_empty_i) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d  = fifo_rd_data_i;
        parity_d = parity_of(fifo_rd_data_i);
        cnt_d    = CntMax;
        state_d  = START;
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = CntMax;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CntMax;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = (ParityEn != 0) ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PARITY: begin
        if (cnt_q == '0) begin
          cnt_d   = CntMax;
          idx_d   = 3'd0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (idx_q == StopLast) begin
            idx_d   = 3'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
            cnt_d = CntMax;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serial line decoded from the state and registered data only.
  always_comb begin
    tx_o = 1'b1;
    unique case (state_q)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shreg_q[0];
      PARITY:  tx_o = parity_q;
      default: tx_o = 1'b1;
    endcase
  end

  assign fifo_rd_en_o = (state_q == FETCH);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2 at 4 clocks/bit)
// fed from FIFO models; frames are checked cycle by cycle against a queue.
module tb_uart_tx;

  localparam int Clks = 4;

  logic       clk;
  logic       rst_n    [4];
  logic       tx_en    [4];
  logic       empty    [4];
  logic [7:0] rd_data  [4];
  logic       rd_en    [4];
  logic       tx       [4];
  logic       busy     [4];
  logic       done     [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  fifo_q  [4][$];
  logic [11:0] exp_q   [4][$];
  int          rd_q    [4][$];
  int          start_q [4][$];
  int          end_q   [4][$];
  int          rd_cnt   [4];
  int          done_cnt [4];
  int          exp_rd   [4];
  int          exp_done [4];

  typedef struct packed {
    logic [1:0]  inst;
    logic [7:0]  data;
    logic [11:0] frame;   // bit k = k-th bit on the line (start first)
  } vec_t;
  vec_t vecs [12];

  uart_tx #(.ClksPerBit(Clks), .ParityEn(0), .ParityOdd(0), .StopBits(1)) u_8n1 (
    .clk_i(clk), .rst_ni(rst_n[0]), .tx_en_i(tx_en[0]), .fifo_empty_i(empty[0]),
    .fifo_rd_data_i(rd_data[0]), .fifo_rd_en_o(rd_en[0]), .tx_o(tx[0]),
    .busy_o(busy[0]), .done_o(done[0]));
  uart_tx #(.ClksPerBit(Clks), .ParityEn(1), .ParityOdd(0), .StopBits(1)) u_8e1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .tx_en_i(tx_en[1]), .fifo_empty_i(empty[1]),
    .fifo_rd_data_i(rd_data[1]), .fifo_rd_en_o(rd_en[1]), .tx_o(tx[1]),
    .busy_o(busy[1]), .done_o(done[1]));
  uart_tx #(.ClksPerBit(Clks), .ParityEn(1), .ParityOdd(1), .StopBits(1)) u_8o1 (
    .clk_i(clk), .rst_ni(rst_n[2]), .tx_en_i(tx_en[2]), .fifo_empty_i(empty[2]),
    .fifo_rd_data_i(rd_data[2]), .fifo_rd_en_o(rd_en[2]), .tx_o(tx[2]),
    .busy_o(busy[2]), .done_o(done[2]));
  uart_tx #(.ClksPerBit(Clks), .ParityEn(0), .ParityOdd(0), .StopBits(2)) u_8n2 (
    .clk_i(clk), .rst_ni(rst_n[3]), .tx_en_i(tx_en[3]), .fifo_empty_i(empty[3]),
    .fifo_rd_data_i(rd_data[3]), .fifo_rd_en_o(rd_en[3]), .tx_o(tx[3]),
    .busy_o(busy[3]), .done_o(done[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int nbits(input int i);
    return (i == 0) ? 10 : 11;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic [11:0] f);
    fifo_q[i].push_back(d);
    exp_q[i].push_back(f);
    empty[i] = 1'b0;
    exp_rd[i]++;
    exp_done[i]++;
  endtask

  // FIFO model: data appears after a pop strobe and is held through LOAD,
  // otherwise the read bus carries garbage.
  task automatic drv(input int i);
    bit hold = 0;
    forever begin
      @(negedge clk);
      if (done[i]) done_cnt[i]++;
      if (rd_en[i]) begin
        rd_cnt[i]++;
        rd_q[i].push_back(cyc);
        if (fifo_q[i].size() == 0) chk($sformatf("fifo_underflow_%0d", i), 1, 0);
        else rd_data[i] = fifo_q[i].pop_front();
        hold = 1;
        empty[i] = (fifo_q[i].size() == 0);
      end else if (hold) begin
        hold = 0;
      end else begin
        rd_data[i] = 8'($urandom);
      end
    end
  endtask

  // Frame monitor: on a start bit, pops the expected frame and compares
  // every cycle of it, then requires the done pulse in the following cycle.
  task automatic mon(input int i);
    logic prev = 1'b1;
    logic [11:0] e;
    logic [11:0] cap;
    int bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (!rst_n[i]) begin
        prev = 1'b1;
      end else if (prev && !tx[i] && busy[i]) begin
        start_q[i].push_back(cyc);
        e = '0;
        if (exp_q[i].size() == 0) chk($sformatf("unexpected_frame_%0d", i), 1, 0);
        else e = exp_q[i].pop_front();
        bad = 0;
        cap = '0;
        aborted = 0;
        for (int k = 0; k < nbits(i) * Clks; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst_n[i]) begin
            aborted = 1;
            break;
          end
          if (k % Clks == 2) cap[k / Clks] = tx[i];
          if (tx[i] !== e[k / Clks]) bad++;
        end
        if (aborted) begin
          prev = 1'b1;
        end else begin
          end_q[i].push_back(cyc);
          n_checks++;
          if (bad != 0) begin
            n_fail++;
            $display("FAIL frame_%0d: got bits %b (%0d bad cycles), required %b",
                     i, cap, bad, e);
          end
          @(negedge clk);
          chk($sformatf("done_after_frame_%0d", i),
              int'(done[i] && !busy[i] && tx[i]), 1);
          prev = tx[i];
        end
      end else begin
        prev = tx[i];
      end
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 &&
          exp_q[3].size() == 0 && !busy[0] && !busy[1] && !busy[2] && !busy[3]) begin
        ok = 1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  initial begin
    int p;
    int viol;
    bit seen;

    vecs[0]  = '{2'd0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}};
    vecs[1]  = '{2'd0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}};
    vecs[2]  = '{2'd0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}};
    vecs[3]  = '{2'd0, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}};
    vecs[4]  = '{2'd1, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}};  // even: parity 1
    vecs[5]  = '{2'd1, 8'hFF, {1'b0, 1'b1, 1'b0, 8'hFF, 1'b0}};  // even: parity 0
    vecs[6]  = '{2'd1, 8'h01, {1'b0, 1'b1, 1'b1, 8'h01, 1'b0}};  // even: parity 1
    vecs[7]  = '{2'd2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}};  // odd: parity 0
    vecs[8]  = '{2'd2, 8'h00, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}};  // odd: parity 1
    vecs[9]  = '{2'd2, 8'hFE, {1'b0, 1'b1, 1'b0, 8'hFE, 1'b0}};  // odd: parity 0
    vecs[10] = '{2'd3, 8'h55, {1'b0, 1'b1, 1'b1, 8'h55, 1'b0}};  // two stop bits
    vecs[11] = '{2'd3, 8'h0F, {1'b0, 1'b1, 1'b1, 8'h0F, 1'b0}};

    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      tx_en[i] = 1'b0;
      empty[i] = 1'b1;
      rd_data[i] = 8'h00;
      rd_cnt[i] = 0;
      done_cnt[i] = 0;
      exp_rd[i] = 0;
      exp_done[i] = 0;
    end

    fork
      drv(0); drv(1); drv(2); drv(3);
      mon(0); mon(1); mon(2); mon(3);
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", int'(tx[0]), 1);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_rd_en", int'(rd_en[0]), 0);
    chk("reset_done", int'(done[0]), 0);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;

    // Enabled but empty FIFO: the line must stay idle
    tx_en[0] = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd_en[0] || !tx[0] || busy[0]) viol++;
    end
    chk("empty_fifo_idle", viol, 0);

    // Table-driven frames, all instances at once
    @(negedge clk);
    for (int i = 0; i < 4; i++) tx_en[i] = 1'b1;
    p = cyc;
    for (int v = 0; v < 12; v++) push(int'(vecs[v].inst), vecs[v].data, vecs[v].frame);
    wait_drain("table_drain");

    chk("latency_rd_en", (rd_q[0].size() > 0) ? rd_q[0][0] - p : -1, 1);
    chk("latency_start", (start_q[0].size() > 0) ? start_q[0][0] - p : -1, 3);
    chk("len_8n1", (end_q[0].size() > 0) ? end_q[0][0] - start_q[0][0] + 1 : -1, 40);
    chk("len_8e1", (end_q[1].size() > 0) ? end_q[1][0] - start_q[1][0] + 1 : -1, 44);
    chk("len_8n2", (end_q[3].size() > 0) ? end_q[3][0] - start_q[3][0] + 1 : -1, 44);
    chk("gap_8n1", (start_q[0].size() > 1) ? start_q[0][1] - end_q[0][0] - 1 : -1, 3);
    chk("gap_8n2", (start_q[3].size() > 1) ? start_q[3][1] - end_q[3][0] - 1 : -1, 3);

    // Reset during DATA bit 3, with a second byte still queued
    @(negedge clk);
    p = cyc;
    push(0, 8'h96, {2'b00, 1'b1, 8'h96, 1'b0});
    push(0, 8'h3A, {2'b00, 1'b1, 8'h3A, 1'b0});
    exp_done[0]--;
    repeat (20) @(negedge clk);
    chk("pre_reset_bit3", int'({busy[0], tx[0]}), 2);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("async_reset_tx", int'(tx[0]), 1);
    chk("async_reset_busy", int'(busy[0]), 0);
    chk("async_reset_done", int'(done[0]), 0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    wait_drain("post_reset_drain");

    // tx_en dropped during the start bit; a further queued byte stays put
    @(negedge clk);
    push(1, 8'h5A, {1'b0, 1'b1, 1'b0, 8'h5A, 1'b0});
    seen = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (busy[1] && !tx[1]) begin
        seen = 1;
        break;
      end
    end
    chk("start_seen_8e1", int'(seen), 1);
    tx_en[1] = 1'b0;
    fifo_q[1].push_back(8'hC3);
    empty[1] = 1'b0;
    wait_drain("txen_drop_drain");
    repeat (20) @(negedge clk);
    chk("txen_drop_busy", int'(busy[1]), 0);

    // Strobe and completion counts per instance
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_en_count_%0d", i), rd_cnt[i], exp_rd[i]);
      chk($sformatf("done_count_%0d", i), done_cnt[i], exp_done[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
